key_expander: RTL
=================

Name: key_expander

Overview:
- Iterative AES key-schedule generator for AES-128, AES-192 and AES-256, selected by Nk = 4, 6 or 8.
- Sits directly upstream of the decryption datapath and drives its 1920-bit keySchedule bus.
- Produces one 32-bit schedule word per clock after a single-cycle key load, then holds the schedule stable with doneFlag high.

Parameters:
- None. Widths are fixed by the keySchedule bus format.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- start  input  1  one-cycle request; accepted only in IDLE or DONE
- Nk  input  8  key length in words: 4, 6 or 8; any other value is treated as 8
- key  input  256  cipher key, left-justified: word0 = key[255:224]; only the top 32*Nk bits are used
- keySchedule  output  1920  expanded words; w[i] = keySchedule[1919-32*i -: 32]; round key r = keySchedule[1919-128*r -: 128]
- busy  output  1  high while expansion is in progress
- doneFlag  output  1  high when keySchedule is complete and stable

Behaviour:
- Reset (reset==0 at a clk edge): keySchedule=0, busy=0, doneFlag=0, state=IDLE, rcon=8'h01, word index i=0, modulo counter j=0.
- States: IDLE, EXPAND, DONE.
- Start (IDLE or DONE, start=1, edge E0):
  - latch Nk and key;
  - zero all of keySchedule, then write w[0..Nk-1] from key;
  - set i=Nk, j=0, rcon=01, busy=1, doneFlag=0; go to EXPAND.
- start is ignored in EXPAND. No restart and no corruption occur.
- EXPAND, one word per edge:
  - temp = w[i-1].
  - If j==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, and rcon <= xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0).
  - Else if Nk==8 and j==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - i <= i+1; j <= (j==Nk-1) ? 0 : j+1. No divider is used.
- Total words = 44 / 52 / 60 for Nk = 4 / 6 / 8.
- On the edge that writes the last word: busy=0, doneFlag=1, go to DONE.
- Latency: doneFlag is visible after edge E0+40 (Nk=4), E0+46 (Nk=6) or E0+52 (Nk=8).
- Unused low bits stay zero: bits 511:0 for Nk=4, bits 255:0 for Nk=6.
- DONE: keySchedule and doneFlag are held until the next accepted start or reset.
- Reset mid-EXPAND: all outputs return to reset values on that edge. No partial schedule is retained.
- Nk or key changes after E0 have no effect until the next start.
- Implementation may keep a sliding window of the last 8 words to source w[i-1] and w[i-Nk], instead of a wide mux.

Decomposition:
- Shared constants include: AES S-box table, RCON_INIT=8'h01, XTIME_POLY=8'h1b, per-Nk total-word counts (44/52/60).
- The S-box table is shared with the cipher and decipher round logic.
- One sub-module: sub_word (32-bit SubWord, built from four combinational S-box lookups).
- The FSM, rcon register and schedule register stay in key_expander.

Test Plan:
- Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - w[4]=a0fafe17;
  - doneFlag rises exactly 40 edges after E0;
  - keySchedule[639:512]=d014f9a8c9ee2589e13f0cc8b6630ca6;
  - bits 511:0 = 0.
- Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - doneFlag after 46 edges;
  - round key 12 = keySchedule[383:256] = e98ba06f448c773c8ecc720401002202.
- Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - doneFlag after 52 edges;
  - keySchedule[127:0]=fe4890d1e6188d0b046df344706c631e.
- Nk=8'h05 with the AES-256 key: result identical to the Nk=8 case.
- start pulsed at edge E0+10 during an Nk=4 run: ignored; final schedule and timing unchanged. Then start in DONE with the Nk=6 key: doneFlag drops at the next edge and the Nk=6 result follows.
- reset driven low at E0+20: next edge gives keySchedule=0, busy=0, doneFlag=0. Deasserting reset and restarting gives a correct Nk=4 result.

Source files
------------

// File: rtl/key_expander_pkg.sv
// Shared AES constants and helpers for the key expander: S-box table, rcon
// arithmetic, Nk decoding and per-key-size schedule lengths.
package key_expander_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1b;
    localparam logic [5:0] WORDS_NK4  = 6'd44;
    localparam logic [5:0] WORDS_NK6  = 6'd52;
    localparam logic [5:0] WORDS_NK8  = 6'd60;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

    // Unsupported key lengths fall back to AES-256.
    function automatic logic [3:0] eff_nk(input logic [7:0] nk);
        case (nk)
            8'd4:    return 4'd4;
            8'd6:    return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [5:0] total_words(input logic [3:0] nk);
        case (nk)
            4'd4:    return WORDS_NK4;
            4'd6:    return WORDS_NK6;
            default: return WORDS_NK8;
        endcase
    endfunction

endpackage

// File: rtl/key_expander_if.sv
// Request/schedule bundle between the key source, the key expander and the
// decryption datapath.
interface key_expander_if;
    // start is a single-cycle request, taken only while busy is low; doneFlag
    // is a level that holds with keySchedule until the next accepted start.
    logic           start;
    logic [7:0]     Nk;
    logic [255:0]   key;
    logic [1919:0]  keySchedule;
    logic           busy;
    logic           doneFlag;

    modport master (output start, Nk, key, input keySchedule, busy, doneFlag);
    modport slave  (input start, Nk, key, output keySchedule, busy, doneFlag);
endinterface

// File: rtl/key_expander_sub_word.sv
// AES SubWord: byte-wise S-box substitution of one 32-bit word.
module key_expander_sub_word
    import key_expander_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/key_expander.sv
// Iterative AES-128/192/256 key schedule: loads the key in one cycle, then
// appends one word per clock into a 60-word schedule held until restart.
module key_expander
    import key_expander_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    key_expander_if.slave bus,
    output state_t        o_dbg_state
);

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_w   [0:59];
    logic [31:0]   r_win [0:7];
    logic [3:0]    r_nk;
    logic [5:0]    r_i;
    logic [2:0]    r_j;
    logic [7:0]    r_rcon;

    logic          w_load;
    logic          w_last;
    logic [3:0]    w_nk_in;
    logic [31:0]   w_key_words [0:7];
    logic [31:0]   w_prev;
    logic [31:0]   w_back;
    logic [31:0]   w_sub_in;
    logic [31:0]   w_sub_out;
    logic [31:0]   w_temp;
    logic [31:0]   w_new;
    logic [1919:0] w_sched;

    assign w_nk_in = eff_nk(bus.Nk);
    assign w_load  = bus.start && (r_state != ST_EXPAND);
    assign w_last  = (r_i == total_words(r_nk) - 6'd1);

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_key_words[k] = bus.key[255 - 32*k -: 32];
        end
    end

    // r_win[0] is w[i-1] and r_win[Nk-1] is w[i-Nk], so no wide mux over the schedule.
    assign w_prev   = r_win[0];
    assign w_back   = r_win[3'(r_nk - 4'd1)];
    assign w_sub_in = (r_j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    key_expander_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_comb begin
        w_temp = w_prev;
        if (r_j == 3'd0) begin
            w_temp = w_sub_out ^ {r_rcon, 24'h0};
        end else if ((r_nk == 4'd8) && (r_j == 3'd4)) begin
            w_temp = w_sub_out;
        end
    end

    assign w_new = w_back ^ w_temp;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.start) w_state_next = ST_EXPAND;
            ST_EXPAND: if (w_last)    w_state_next = ST_DONE;
            ST_DONE:   if (bus.start) w_state_next = ST_EXPAND;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_nk    <= 4'd8;
            r_i     <= 6'd0;
            r_j     <= 3'd0;
            r_rcon  <= RCON_INIT;
            for (int k = 0; k < 60; k++) r_w[k] <= 32'h0;
            for (int k = 0; k < 8; k++)  r_win[k] <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_nk   <= w_nk_in;
                r_i    <= 6'(w_nk_in);
                r_j    <= 3'd0;
                r_rcon <= RCON_INIT;
                for (int k = 0; k < 60; k++) begin
                    r_w[k] <= (k < int'(w_nk_in)) ? w_key_words[3'(k)] : 32'h0;
                end
                for (int k = 0; k < 8; k++) begin
                    r_win[k] <= (k < int'(w_nk_in)) ? w_key_words[3'(int'(w_nk_in) - 1 - k)] : 32'h0;
                end
            end else if (r_state == ST_EXPAND) begin
                r_w[r_i] <= w_new;
                r_win[0] <= w_new;
                for (int k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
                r_i <= r_i + 6'd1;
                r_j <= (r_j == 3'(r_nk - 4'd1)) ? 3'd0 : r_j + 3'd1;
                if (r_j == 3'd0) r_rcon <= xtime(r_rcon);
            end
        end
    end

    always_comb begin
        w_sched = '0;
        for (int k = 0; k < 60; k++) begin
            w_sched[1919 - 32*k -: 32] = r_w[k];
        end
    end

    assign bus.keySchedule = w_sched;
    assign bus.busy        = (r_state == ST_EXPAND);
    assign bus.doneFlag    = (r_state == ST_DONE);
    assign o_dbg_state     = r_state;

endmodule
